// File: rtl/sram_test.sv
// sram_test: single-cycle bus controller in front of a behavioural
// asynchronous SRAM (fake_sram_instance). Reads return registered data one
// edge after the request; writes commit on the request edge.
//
// Build option: define SRAM_ALIGN_EN to clear bus_addr[1:0] before every
// access (word-aligned only). Without it, unaligned byte addresses are
// honoured and the four byte lanes wrap modulo MEM_BYTES.

package SramTestPkg;
  typedef logic [19:0] Ram_addr_t;
  typedef logic [31:0] Word_t;
endpackage

// Behavioural asynchronous SRAM with active-low strobes and byte enables.
// Storage is a flat little-endian byte array so it can be preloaded from a
// hex image and inspected hierarchically. The word address plus a byte
// offset selects the first byte; the remaining lanes follow it, wrapping
// around the end of the array.
module FakeSram #(
  parameter int MEM_BYTES = 1048576,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk_i,
  input  logic          ce_n_i,
  input  logic          oe_n_i,
  input  logic          we_n_i,
  input  logic [3:0]    be_n_i,
  input  logic [AW-3:0] word_addr_i,
  input  logic [1:0]    byte_off_i,
  input  logic [31:0]   data_i,
  output logic [31:0]   data_o
);

  logic [7:0]    sram_mem [0:MEM_BYTES-1];
  logic [AW-1:0] laneIdx  [4];

  // Byte index of each lane; the AW-bit add wraps modulo MEM_BYTES for free.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      laneIdx[i] = {word_addr_i, byte_off_i} + AW'(i);
    end
  end

  // The controller releases we_n on the clock edge, so the write lands there.
  always_ff @(posedge clk_i) begin
    if (!ce_n_i && !we_n_i) begin
      for (int i = 0; i < 4; i++) begin
        if (!be_n_i[i]) begin
          sram_mem[laneIdx[i]] <= data_i[8*i +: 8];
        end
      end
    end
  end

  // Asynchronous read path; undriven lanes and a deselected chip return zero.
  always_comb begin
    data_o = '0;
    if (!ce_n_i && !oe_n_i && we_n_i) begin
      for (int i = 0; i < 4; i++) begin
        if (!be_n_i[i]) begin
          data_o[8*i +: 8] = sram_mem[laneIdx[i]];
        end
      end
    end
  end

endmodule

module sram_test
  import SramTestPkg::*;
#(
  parameter int MEM_BYTES = 1048576
) (
  input  logic      clk,
  input  logic      rst,
  input  Ram_addr_t bus_addr,
  input  logic      read_op,
  input  logic      write_op,
  input  Word_t     bus_data_write,
  output Word_t     bus_data_read
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } ctrl_state_e;

  ctrl_state_e   state_d;
  logic          isWrite;
  Ram_addr_t     effAddr;
  logic          ceN;
  logic          oeN;
  logic          weN;
  logic [3:0]    beN;
  Word_t         sramRdata;
  Word_t         bus_data_read_d;
  Word_t         bus_data_read_q;

  // Effective address: optionally forced onto a word boundary.
`ifdef SRAM_ALIGN_EN
  assign effAddr = bus_addr & 20'hFFFFC;
`else
  assign effAddr = bus_addr;
`endif

  // Two-phase controller. An access is started and finished between two
  // rising edges, so the machine is back in IDLE at every edge and the phase
  // is decided purely from this cycle's request; reset pins it to IDLE, which
  // also drops any request that arrives while reset is asserted.
  always_comb begin
    state_d = IDLE;
    isWrite = 1'b0;
    if (!rst && (read_op || write_op)) begin
      state_d = ACCESS;
      isWrite = write_op;
    end
  end

  // SRAM strobes: all deasserted outside ACCESS; write wins over read.
  always_comb begin
    ceN = 1'b1;
    oeN = 1'b1;
    weN = 1'b1;
    beN = 4'hF;
    if (state_d == ACCESS) begin
      ceN = 1'b0;
      beN = 4'h0;
      if (isWrite) begin
        weN = 1'b0;
      end else begin
        oeN = 1'b0;
      end
    end
  end

  FakeSram #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) fake_sram_instance (
    .clk_i       (clk),
    .ce_n_i      (ceN),
    .oe_n_i      (oeN),
    .we_n_i      (weN),
    .be_n_i      (beN),
    .word_addr_i (effAddr[AW-1:2]),
    .byte_off_i  (effAddr[1:0]),
    .data_i      (bus_data_write),
    .data_o      (sramRdata)
  );

  // Read data only moves on a completed read; otherwise it holds.
  always_comb begin
    bus_data_read_d = bus_data_read_q;
    if (state_d == ACCESS && !isWrite) begin
      bus_data_read_d = sramRdata;
    end
  end

  // Registered read data with synchronous clear; memory is never reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_data_read_q <= '0;
    end else begin
      bus_data_read_q <= bus_data_read_d;
    end
  end

  assign bus_data_read = bus_data_read_q;

endmodule

// File: tb/tb_sram_test.sv
// Self-checking bench for sram_test: directed scenarios plus randomized
// traffic inside a 64-byte window that straddles the top/bottom of memory,
// compared against a byte-level reference model.
module tb_sram_test;

  localparam int MEM = 1048576;
  localparam int WIN = 64;

  logic        clk;
  logic        rst;
  logic [19:0] bus_addr;
  logic        read_op;
  logic        write_op;
  logic [31:0] bus_data_write;
  logic [31:0] bus_data_read;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference model: bytes MEM-32..MEM-1 then 0..31 as one contiguous window.
  logic [7:0]  refMem [WIN];
  logic [31:0] expRead;

  sram_test #(.MEM_BYTES(MEM)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus_addr       (bus_addr),
    .read_op        (read_op),
    .write_op       (write_op),
    .bus_data_write (bus_data_write),
    .bus_data_read  (bus_data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int winIdx(input longint a);
    return int'((a + 32) % MEM);
  endfunction

  function automatic longint effAddr(input longint a);
`ifdef SRAM_ALIGN_EN
    return a - (a % 4);
`else
    return a;
`endif
  endfunction

  function automatic logic [31:0] modelWord(input longint a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = refMem[winIdx((a + i) % MEM)];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle, advance the model with the bus rules, check read data.
  task automatic applyStimulus(input logic r, input logic rd, input logic wr,
                               input logic [19:0] a, input logic [31:0] d,
                               input string tag);
    longint ea;
    @(negedge clk);
    rst = r; read_op = rd; write_op = wr; bus_addr = a; bus_data_write = d;
    @(posedge clk);
    #1;
    ea = effAddr(longint'(a));
    if (r) begin
      expRead = 32'h0;
    end else if (wr) begin
      for (int i = 0; i < 4; i++) refMem[winIdx((ea + i) % MEM)] = d[8*i +: 8];
    end else if (rd) begin
      expRead = modelWord(ea);
    end
    checkOutput(tag, bus_data_read, expRead);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 32'h0, tag);
  endtask

  initial begin
    logic [19:0] a;
    logic [31:0] d;
    int op;
    logic r;
    rst = 1'b1; read_op = 1'b0; write_op = 1'b0;
    bus_addr = '0; bus_data_write = '0;
    expRead = 32'h0;
    for (int i = 0; i < WIN; i++) refMem[i] = 8'h00;

    // Reset with a request pending: must be ignored and clear read data.
    applyStimulus(1'b1, 1'b1, 1'b0, 20'h0, 32'h0, "reset0");
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h0, 32'h0, "reset1");

    // Fill the whole window with random aligned words.
    for (int k = 0; k < WIN / 4; k++) begin
      a = 20'((MEM - 32 + 4 * k) % MEM);
      applyStimulus(1'b0, 1'b0, 1'b1, a, $urandom, "init");
    end

    // Known pattern at 0 then read it back.
    applyStimulus(1'b0, 1'b0, 1'b1, 20'd0, 32'h12345678, "wr0");
    applyStimulus(1'b0, 1'b1, 1'b0, 20'd0, 32'h0, "rd0");
    checkOutput("rd0_const", bus_data_read, 32'h12345678);

    // Little-endian byte placement of a write, visible right after the edge.
    applyStimulus(1'b0, 1'b0, 1'b1, 20'd8, 32'hDEADBEEF, "wr8");
    checkOutput("mem8",  {24'h0, dut.fake_sram_instance.sram_mem[8]},  32'hEF);
    checkOutput("mem9",  {24'h0, dut.fake_sram_instance.sram_mem[9]},  32'hBE);
    checkOutput("mem10", {24'h0, dut.fake_sram_instance.sram_mem[10]}, 32'hAD);
    checkOutput("mem11", {24'h0, dut.fake_sram_instance.sram_mem[11]}, 32'hDE);

    // Write, idle (read data must hold), then read back.
    applyStimulus(1'b0, 1'b0, 1'b1, 20'd4, 32'hA5A5A5A5, "wr4");
    idleCycle("idle_hold");
    checkOutput("idle_hold_const", bus_data_read, 32'h12345678);
    applyStimulus(1'b0, 1'b1, 1'b0, 20'd4, 32'h0, "rd4");
    checkOutput("rd4_const", bus_data_read, 32'hA5A5A5A5);

    // Read and write together: write wins, read data holds.
    applyStimulus(1'b0, 1'b1, 1'b1, 20'd16, 32'h01020304, "both16");
    checkOutput("both16_hold", bus_data_read, 32'hA5A5A5A5);
    checkOutput("mem16", {24'h0, dut.fake_sram_instance.sram_mem[16]}, 32'h04);
    checkOutput("mem19", {24'h0, dut.fake_sram_instance.sram_mem[19]}, 32'h01);

    // Read, then reset clears read data while a write is ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 20'd0, 32'h0, "rd0_again");
    applyStimulus(1'b1, 1'b0, 1'b1, 20'd0, 32'hFFFFFFFF, "rst_mid");
    checkOutput("rst_mid_const", bus_data_read, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 20'd0, 32'h0, "rd0_after_rst");
    checkOutput("rd0_after_rst_const", bus_data_read, 32'h12345678);

    // Read near the top of memory: upper lanes wrap to address 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 20'(MEM - 2), 32'h0, "rd_wrap");
`ifndef SRAM_ALIGN_EN
    checkOutput("rd_wrap_const", bus_data_read[31:16], 32'h5678);
`endif

    // Randomized traffic, including unaligned and wrapping addresses.
    for (int n = 0; n < 300; n++) begin
      a  = 20'((MEM - 32 + $urandom_range(0, WIN - 4)) % MEM);
      d  = $urandom;
      op = $urandom_range(0, 3);
      r  = ($urandom_range(0, 99) < 4);
      applyStimulus(r, op[0], op[1], a, d, "random");
    end

    // Final sweep of the window's contents against the model.
    idleCycle("final_idle");
    for (int i = 0; i < WIN; i++) begin
      checkOutput("final_mem",
                  {24'h0, dut.fake_sram_instance.sram_mem[(MEM - 32 + i) % MEM]},
                  {24'h0, refMem[i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compareCount, mismatchCount);
    $finish;
  end

endmodule
